multicycle_control: RTL and testbench

Multi-cycle controller for the RISC-V SiMPLE SV core: a state machine that sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. Instruction and data memory use a ready handshake, so memory may take any number of wait cycles. A programmable wait timeout and an illegal-opcode trap stop the core in a HALT state with a recorded cause. It sits between the instruction register and the shared multicycle datapath (PC, IR, regfile, ALU, memory ports).

---
 rtl/multicycle_control_pkg.sv | 58 +++++
 rtl/multicycle_control_decode.sv | 79 +++++++
 rtl/multicycle_control.sv | 128 ++++++++++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and control encodings for the multi-cycle RISC-V controller.
// The FSM state set, trap causes, opcode classes and datapath select codes live here.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } ctl_state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_FENCE
    } opcode_class_t;

    localparam logic [1:0] CTL_TRAP_NONE    = 2'd0;
    localparam logic [1:0] CTL_TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] CTL_TRAP_TIMEOUT = 2'd2;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

    localparam logic       CTL_ALU_A_RS1 = 1'b0;
    localparam logic       CTL_ALU_A_PC  = 1'b1;
    localparam logic       CTL_ALU_B_RS2 = 1'b0;
    localparam logic       CTL_ALU_B_IMM = 1'b1;

    localparam logic [2:0] CTL_ALU_ADD    = 3'd0;
    localparam logic [2:0] CTL_ALU_OP     = 3'd1;
    localparam logic [2:0] CTL_ALU_OP_IMM = 3'd2;
    localparam logic [2:0] CTL_ALU_BRANCH = 3'd3;

    localparam logic [2:0] CTL_WRITEBACK_ALU  = 3'd0;
    localparam logic [2:0] CTL_WRITEBACK_DATA = 3'd1;
    localparam logic [2:0] CTL_WRITEBACK_PC4  = 3'd2;
    localparam logic [2:0] CTL_WRITEBACK_IMM  = 3'd3;

    localparam logic [1:0] CTL_PC_PC4     = 2'd0;
    localparam logic [1:0] CTL_PC_PC_IMM  = 2'd1;
    localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode decoder: opcode class plus every datapath select.
// Illegal opcodes decode to class CLS_ILLEGAL with all selects at zero.
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] inst_opcode,
    input  logic       take_branch,
    output logic [2:0] op_class,
    output logic       alu_operand_a_select,
    output logic       alu_operand_b_select,
    output logic [2:0] alu_op_type,
    output logic [2:0] reg_writeback_select,
    output logic [1:0] next_pc_select
);

    always_comb begin
        op_class             = CLS_ILLEGAL;
        alu_operand_a_select = CTL_ALU_A_RS1;
        alu_operand_b_select = CTL_ALU_B_RS2;
        alu_op_type          = CTL_ALU_ADD;
        reg_writeback_select = CTL_WRITEBACK_ALU;
        next_pc_select       = CTL_PC_PC4;
        case (inst_opcode)
            OPCODE_OP: begin
                op_class    = CLS_ALU;
                alu_op_type = CTL_ALU_OP;
            end
            OPCODE_OP_IMM: begin
                op_class             = CLS_ALU;
                alu_operand_b_select = CTL_ALU_B_IMM;
                alu_op_type          = CTL_ALU_OP_IMM;
            end
            OPCODE_AUIPC: begin
                op_class             = CLS_ALU;
                alu_operand_a_select = CTL_ALU_A_PC;
                alu_operand_b_select = CTL_ALU_B_IMM;
            end
            OPCODE_LUI: begin
                op_class             = CLS_ALU;
                alu_operand_b_select = CTL_ALU_B_IMM;
                reg_writeback_select = CTL_WRITEBACK_IMM;
            end
            OPCODE_LOAD: begin
                op_class             = CLS_LOAD;
                alu_operand_b_select = CTL_ALU_B_IMM;
                reg_writeback_select = CTL_WRITEBACK_DATA;
            end
            OPCODE_STORE: begin
                op_class             = CLS_STORE;
                alu_operand_b_select = CTL_ALU_B_IMM;
            end
            OPCODE_BRANCH: begin
                op_class       = CLS_BRANCH;
                alu_op_type    = CTL_ALU_BRANCH;
                next_pc_select = take_branch ? CTL_PC_PC_IMM : CTL_PC_PC4;
            end
            OPCODE_JAL: begin
                op_class             = CLS_JUMP;
                alu_operand_a_select = CTL_ALU_A_PC;
                alu_operand_b_select = CTL_ALU_B_IMM;
                reg_writeback_select = CTL_WRITEBACK_PC4;
                next_pc_select       = CTL_PC_PC_IMM;
            end
            OPCODE_JALR: begin
                op_class             = CLS_JUMP;
                alu_operand_b_select = CTL_ALU_B_IMM;
                reg_writeback_select = CTL_WRITEBACK_PC4;
                next_pc_select       = CTL_PC_RS1_IMM;
            end
            OPCODE_MISC_MEM: begin
                op_class = CLS_FENCE;
            end
            default: begin
                op_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with ready handshakes,
// a per-access wait timeout and an absorbing HALT state that records the trap cause.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] inst_opcode,
    input  logic       take_branch,
    input  logic       inst_mem_ready,
    input  logic       data_mem_ready,
    output logic       inst_mem_read_enable,
    output logic       ir_write_enable,
    output logic       pc_write_enable,
    output logic       regfile_write_enable,
    output logic       alu_operand_a_select,
    output logic       alu_operand_b_select,
    output logic [2:0] alu_op_type,
    output logic       data_mem_read_enable,
    output logic       data_mem_write_enable,
    output logic [2:0] reg_writeback_select,
    output logic [1:0] next_pc_select,
    output logic       instret,
    output logic       halted,
    output logic [1:0] trap_cause
);

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    ctl_state_t    state;
    logic [CW-1:0] wait_count;
    logic [2:0]    class_bits;
    opcode_class_t op_class;
    logic          run;
    logic          access_ready;
    logic          timed_out;
    logic          retire;

    multicycle_control_decode decode (
        .inst_opcode          (inst_opcode),
        .take_branch          (take_branch),
        .op_class             (class_bits),
        .alu_operand_a_select (alu_operand_a_select),
        .alu_operand_b_select (alu_operand_b_select),
        .alu_op_type          (alu_op_type),
        .reg_writeback_select (reg_writeback_select),
        .next_pc_select       (next_pc_select)
    );

    assign op_class = opcode_class_t'(class_bits);
    assign run      = !reset;

    // Ready of whichever memory access the current state is waiting on.
    assign access_ready = (state == FETCH) ? inst_mem_ready : data_mem_ready;
    assign timed_out    = (WAIT_LIMIT > 0) && !access_ready && (wait_count == CW'(WAIT_LIMIT));

    assign retire = run && (
        ((state == EXECUTE) && ((op_class == CLS_BRANCH) || (op_class == CLS_FENCE))) ||
        ((state == MEM) && (op_class == CLS_STORE) && data_mem_ready) ||
        (state == WRITEBACK));

    assign inst_mem_read_enable  = run && (state == FETCH);
    assign ir_write_enable       = run && (state == FETCH) && inst_mem_ready;
    assign data_mem_read_enable  = run && (state == MEM) && (op_class == CLS_LOAD);
    assign data_mem_write_enable = run && (state == MEM) && (op_class == CLS_STORE);
    assign regfile_write_enable  = run && (state == WRITEBACK);
    assign pc_write_enable       = retire;
    assign instret               = retire;
    assign halted                = run && (state == HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FETCH;
            wait_count <= '0;
            trap_cause <= CTL_TRAP_NONE;
        end else begin
            case (state)
                FETCH: begin
                    if (inst_mem_ready) begin
                        state <= DECODE;
                    end else if (timed_out) begin
                        state      <= HALT;
                        trap_cause <= CTL_TRAP_TIMEOUT;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
                end
                DECODE: begin
                    if (op_class == CLS_ILLEGAL) begin
                        state      <= HALT;
                        trap_cause <= CTL_TRAP_ILLEGAL;
                    end else begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    wait_count <= '0;
                    case (op_class)
                        CLS_ALU, CLS_JUMP:    state <= WRITEBACK;
                        CLS_LOAD, CLS_STORE:  state <= MEM;
                        default:              state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (data_mem_ready) begin
                        state      <= (op_class == CLS_LOAD) ? WRITEBACK : FETCH;
                        wait_count <= '0;
                    end else if (timed_out) begin
                        state      <= HALT;
                        trap_cause <= CTL_TRAP_TIMEOUT;
                    end else begin
                        wait_count <= wait_count + CW'(1);
                    end
                end
                WRITEBACK: begin
                    state      <= FETCH;
                    wait_count <= '0;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions with random memory
// wait states, checked against a per-instruction timeline model.
module tb_multicycle_control;

    localparam int WL = 4;

    localparam int K_ILL = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3,
                   K_BRANCH = 4, K_JUMP = 5, K_FENCE = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] inst_opcode = 7'd0;
    logic       take_branch = 1'b0;
    logic       inst_mem_ready = 1'b0;
    logic       data_mem_ready = 1'b0;
    logic       inst_mem_read_enable;
    logic       ir_write_enable;
    logic       pc_write_enable;
    logic       regfile_write_enable;
    logic       alu_operand_a_select;
    logic       alu_operand_b_select;
    logic [2:0] alu_op_type;
    logic       data_mem_read_enable;
    logic       data_mem_write_enable;
    logic [2:0] reg_writeback_select;
    logic [1:0] next_pc_select;
    logic       instret;
    logic       halted;
    logic [1:0] trap_cause;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multicycle_control #(.WAIT_LIMIT(WL)) dut (
        .clock                (clock),
        .reset                (reset),
        .inst_opcode          (inst_opcode),
        .take_branch          (take_branch),
        .inst_mem_ready       (inst_mem_ready),
        .data_mem_ready       (data_mem_ready),
        .inst_mem_read_enable (inst_mem_read_enable),
        .ir_write_enable      (ir_write_enable),
        .pc_write_enable      (pc_write_enable),
        .regfile_write_enable (regfile_write_enable),
        .alu_operand_a_select (alu_operand_a_select),
        .alu_operand_b_select (alu_operand_b_select),
        .alu_op_type          (alu_op_type),
        .data_mem_read_enable (data_mem_read_enable),
        .data_mem_write_enable(data_mem_write_enable),
        .reg_writeback_select (reg_writeback_select),
        .next_pc_select       (next_pc_select),
        .instret              (instret),
        .halted               (halted),
        .trap_cause           (trap_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int op_kind(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111: return K_ALU;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BRANCH;
            7'b1101111, 7'b1100111: return K_JUMP;
            7'b0001111: return K_FENCE;
            default: return K_ILL;
        endcase
    endfunction

    // Called just after a falling edge; leaves the bench in FETCH cycle 1.
    task automatic do_reset();
        reset = 1'b1;
        inst_mem_ready = 1'b0;
        data_mem_ready = 1'b0;
        #1;
        check("rst_fetch_en", inst_mem_read_enable, 0);
        check("rst_dmem_en", data_mem_read_enable | data_mem_write_enable, 0);
        check("rst_retire", instret | pc_write_enable | regfile_write_enable, 0);
        check("rst_halted", halted, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_fetch", inst_mem_read_enable, 1);
        check("post_rst_cause", trap_cause, 0);
    endtask

    // Runs one instruction from FETCH cycle 1, answering memory after fw / mw wait cycles.
    task automatic run_instr(input logic [6:0] op, input logic tb, input int fw, input int mw);
        int k = op_kind(op);
        int f = fw + 1;
        int exp_end = 0, exp_cause = 0, exp_ireq = f, exp_rd = 0, exp_wr = 0, exp_rf = 0;
        int exp_npc = 0, exp_wb = 0;
        bit exp_halt = 0;
        int cyc = 0, ireq = 0, dreq = 0, rd = 0, wr = 0, rf = 0, rf_cyc = 0;
        int pc_cnt = 0, pc_cyc = 0, ir_cnt = 0, npc = 0, halt_seen = 0, wb = 0;
        bit done = 0;

        if (k == K_BRANCH) exp_npc = tb ? 1 : 0;
        else if (op == 7'b1100111) exp_npc = 2;
        else if (op == 7'b1101111) exp_npc = 1;
        if (k == K_LOAD) exp_wb = 1;
        else if (k == K_JUMP) exp_wb = 2;
        else if (op == 7'b0110111) exp_wb = 3;

        if (fw > WL) begin
            exp_halt = 1; exp_cause = 2; exp_ireq = WL + 1; exp_end = WL + 2;
        end else if (k == K_ILL) begin
            exp_halt = 1; exp_cause = 1; exp_end = f + 2;
        end else if (k == K_LOAD || k == K_STORE) begin
            if (mw > WL) begin
                exp_halt = 1; exp_cause = 2; exp_end = f + 2 + (WL + 1) + 1;
                if (k == K_LOAD) exp_rd = WL + 1; else exp_wr = WL + 1;
            end else begin
                exp_end = f + 2 + (mw + 1) + ((k == K_LOAD) ? 1 : 0);
                if (k == K_LOAD) begin exp_rd = mw + 1; exp_rf = 1; end
                else exp_wr = mw + 1;
            end
        end else if (k == K_ALU || k == K_JUMP) begin
            exp_end = f + 3; exp_rf = 1;
        end else begin
            exp_end = f + 2;
        end

        inst_opcode = op;
        take_branch = tb;
        #1;
        while (!done && cyc < 60) begin
            inst_mem_ready = inst_mem_read_enable && (ireq == fw);
            data_mem_ready = (data_mem_read_enable || data_mem_write_enable) && (dreq == mw);
            #1;
            cyc++;
            wb = int'(reg_writeback_select);
            if (inst_mem_read_enable) ireq++;
            if (data_mem_read_enable) begin rd++; dreq++; end
            if (data_mem_write_enable) begin wr++; dreq++; end
            if (regfile_write_enable) begin rf++; rf_cyc = cyc; end
            if (pc_write_enable) begin pc_cnt++; pc_cyc = cyc; npc = int'(next_pc_select); end
            if (instret) begin ir_cnt++; done = 1; end
            if (halted) begin halt_seen = 1; done = 1; end
            @(negedge clock);
        end
        inst_mem_ready = 1'b0;
        data_mem_ready = 1'b0;

        check("completed", done, 1);
        check("halted", halt_seen, exp_halt);
        check("end_cycle", cyc, exp_end);
        check("fetch_cycles", ireq, exp_ireq);
        check("dmem_read_cycles", rd, exp_rd);
        check("dmem_write_cycles", wr, exp_wr);
        check("regfile_writes", rf, exp_rf);
        check("wb_select", wb, exp_wb);
        if (exp_halt) begin
            check("trap_cause", trap_cause, exp_cause);
            check("halt_instret", ir_cnt, 0);
            check("halt_pc_write", pc_cnt, 0);
            do_reset();
        end else begin
            check("instret_count", ir_cnt, 1);
            check("pc_write_count", pc_cnt, 1);
            check("pc_write_cycle", pc_cyc, exp_end);
            check("next_pc_select", npc, exp_npc);
            if (exp_rf == 1) check("regfile_write_cycle", rf_cyc, exp_end);
        end
    endtask

    logic [6:0] op_table [11];

    initial begin
        op_table = '{7'b0110011, 7'b0010011, 7'b0010111, 7'b0110111, 7'b0000011, 7'b0100011,
                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1111111};

        repeat (3) @(negedge clock);
        do_reset();

        run_instr(7'b0110011, 1'b0, 0, 0);   // ADD, zero wait
        run_instr(7'b0000011, 1'b0, 0, 3);   // LOAD, data ready after 3 waits
        run_instr(7'b1100011, 1'b1, 0, 0);   // taken branch
        run_instr(7'b1100011, 1'b0, 0, 0);   // not-taken branch
        run_instr(7'b1101111, 1'b0, 0, 0);   // JAL
        run_instr(7'b1100111, 1'b0, 1, 0);   // JALR
        run_instr(7'b0100011, 1'b0, 0, 0);   // STORE, zero wait

        inst_opcode = 7'b1111111;
        #1;
        check("illegal_selects",
              {alu_operand_a_select, alu_operand_b_select, alu_op_type, reg_writeback_select},
              0);
        run_instr(7'b1111111, 1'b0, 0, 0);   // illegal opcode trap

        run_instr(7'b0110011, 1'b0, WL + 1, 0);   // fetch timeout
        run_instr(7'b0110011, 1'b0, WL, 0);       // ready in the last allowed cycle
        run_instr(7'b0100011, 1'b0, 0, WL + 1);   // store timeout
        run_instr(7'b0000011, 1'b0, 0, WL);       // load ready in last allowed cycle

        // Reset in the middle of a STORE data wait.
        inst_opcode = 7'b0100011;
        take_branch = 1'b0;
        inst_mem_ready = 1'b1;
        #1;
        @(negedge clock);
        inst_mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        data_mem_ready = 1'b0;
        #1;
        check("store_wait_write_en", data_mem_write_enable, 1);
        @(negedge clock);
        #1;
        check("store_wait_no_retire", instret, 0);
        do_reset();
        check("after_store_reset_write_en", data_mem_write_enable, 0);

        for (int n = 0; n < 40; n++) begin
            int idx, fw, mw;
            idx = ($urandom_range(0, 15) == 0) ? 10 : $urandom_range(0, 9);
            fw  = ($urandom_range(0, 9) == 0) ? WL + 1 : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 9) == 0) ? WL + 1 : $urandom_range(0, WL);
            run_instr(op_table[idx], 1'($urandom_range(0, 1)), fw, mw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
